// File: rtl/greenhouse_pkg.sv
// Shared definitions for the greenhouse sensor front end: DHT11 reader
// state encoding, protocol timing constants and frame helper functions.
package greenhouse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      REL,
      RSP_LO,
      RSP_HI,
      BIT_LO,
      BIT_HI,
      CHECK
   } dht_state_t;

   localparam int unsigned START_US   = 18_000;
   localparam int unsigned TIMEOUT_US = 100;
   localparam int unsigned BIT_ONE_US = 40;
   localparam int unsigned FRAME_BITS = 40;
   localparam logic [7:0]  HUM_MAX    = 8'd100;

   function automatic logic [7:0] clamp_hum(input logic [7:0] b);
      return (b > HUM_MAX) ? HUM_MAX : b;
   endfunction

   // B4 must equal the 8-bit wrapped sum of B0..B3
   function automatic logic frame_ok(input logic [39:0] f);
      logic [7:0] s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return s == f[7:0];
   endfunction

endpackage

// File: rtl/us_tick.sv
// One-clock pulse every microsecond, derived from CLK_HZ.
// Ports: clk, rst (async, active high), tick (1-cycle pulse per us).
module us_tick #(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned DIV =
      (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dht11_reader.sv
// Periodically reads a DHT11 over its single-wire bus and publishes
// humidity (clamped to 100) and temperature from checksum-valid frames.
// Ports: clk, rst (async, active high), dht_in (raw line level),
//        dht_oe (1 = pull line low), humidity, temperature,
//        valid (1-cycle update pulse), error (last read failed).
module dht11_reader
   import greenhouse_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned POLL_MS = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic [7:0] humidity,
   output logic [7:0] temperature,
   output logic       valid,
   output logic       error
);

   localparam logic [31:0] POLL_LAST  = 32'(POLL_MS * 1000 - 1);
   localparam logic [31:0] START_LAST = 32'(START_US - 1);
   localparam logic [31:0] TMO        = 32'(TIMEOUT_US);
   localparam logic [31:0] ONE_W      = 32'(BIT_ONE_US);
   localparam logic [5:0]  LAST_BIT   = 6'(FRAME_BITS - 1);

   dht_state_t  state, nxt;
   logic        tick;
   logic [1:0]  sync;
   logic [1:0]  oe_q;
   logic        line;
   logic [31:0] us_cnt;
   logic [5:0]  bit_cnt;
   logic [39:0] data;
   logic        late;
   logic        fail;
   logic        shift;

   us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign line   = sync[1];
   assign dht_oe = (state == START);
   assign late   = tick && (us_cnt >= TMO);

   // oe_q tracks our own drive through the same two-flop delay as the
   // synchronizer, so the low we forced during START is not taken as
   // the sensor's response once we let go of the line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
         oe_q <= 2'b00;
      end else begin
         sync <= {sync[0], dht_in};
         oe_q <= {oe_q[0], dht_oe};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt   = state;
      fail  = 1'b0;
      shift = 1'b0;
      unique case (state)
         IDLE:
            if (tick && us_cnt >= POLL_LAST) nxt = START;
         START:
            if (tick && us_cnt >= START_LAST) nxt = REL;
         REL:
            if (!line && !oe_q[1]) nxt = RSP_LO;
            else if (late) fail = 1'b1;
         RSP_LO:
            if (line) nxt = RSP_HI;
            else if (late) fail = 1'b1;
         RSP_HI:
            if (!line) nxt = BIT_LO;
            else if (late) fail = 1'b1;
         BIT_LO:
            if (line) nxt = BIT_HI;
            else if (late) fail = 1'b1;
         BIT_HI:
            if (!line) begin
               shift = 1'b1;
               nxt   = (bit_cnt == LAST_BIT) ? CHECK : BIT_LO;
            end else if (late) begin
               fail = 1'b1;
            end
         CHECK:
            nxt = IDLE;
         default:
            nxt = IDLE;
      endcase
      if (fail) nxt = IDLE;
   end

   // us_cnt restarts on every state change, so it doubles as poll timer,
   // START width, timeout and high-width counter. It reads 0 on the first
   // high sample, so a count of 40 means more than 40 us high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         us_cnt      <= '0;
         bit_cnt     <= '0;
         data        <= '0;
         humidity    <= '0;
         temperature <= '0;
         valid       <= 1'b0;
         error       <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (nxt != state) begin
            us_cnt <= '0;
         end else if (tick) begin
            us_cnt <= us_cnt + 1'b1;
         end
         if (state == START) begin
            bit_cnt <= '0;
            data    <= '0;
         end else if (shift) begin
            data    <= {data[38:0], us_cnt >= ONE_W};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (fail) error <= 1'b1;
         if (state == CHECK) begin
            if (frame_ok(data)) begin
               humidity    <= clamp_hum(data[39:32]);
               temperature <= data[23:16];
               error       <= 1'b0;
               valid       <= 1'b1;
            end else begin
               error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/dht11_reader.md
DHT11_READER -- requirements
Module: dht11_reader

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter POLL_MS, default 2000, interval between sensor reads in ms.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dht_in  input  1  sampled level of DHT11 data line, asynchronous to clk.
REQ-006 SHALL have port dht_oe  output  1  1 = drive data line low (open-drain); 0 = release.
REQ-007 SHALL have port humidity  output  8  last valid relative humidity, integer %, range 0..100.
REQ-008 SHALL have port temperature  output  8  last valid temperature, integer deg C.
REQ-009 SHALL have port valid  output  1  one-cycle pulse when humidity/temperature update.
REQ-010 SHALL have port error  output  1  1 when the last read failed (timeout or checksum); cleared by next good read.

Function
REQ-011 SHALL derive a 1 us tick from CLK_HZ/1_000_000 clocks; all protocol timing counts in us.
REQ-012 SHALL pass dht_in through a 2-flop synchronizer before any use; 2-cycle latency is acceptable.
REQ-013 SHALL implement states IDLE, START, REL, RSP_LO, RSP_HI, BIT_LO, BIT_HI, CHECK.
REQ-014 IDLE: dht_oe=0; after POLL_MS ms -> START; first read starts POLL_MS after reset release.
REQ-015 START: dht_oe=1 for exactly 18_000 us, then dht_oe=0 -> REL.
REQ-016 REL: wait for synchronized line low -> RSP_LO; >100 us -> timeout.
REQ-017 RSP_LO: wait for line high -> RSP_HI; RSP_HI: wait for line low -> BIT_LO; each >100 us -> timeout.
REQ-018 BIT_LO: wait for line high -> BIT_HI (reset width counter); >100 us -> timeout.
REQ-019 BIT_HI: on line low, shift in 1 if high width > 40 us else 0, MSB first; >100 us -> timeout.
REQ-020 SHALL capture exactly 40 bits (5 bytes B0..B4); after bit 40 -> CHECK; no further edges awaited.
REQ-021 CHECK: good iff B4 == (B0+B1+B2+B3) mod 256 (8-bit wrap).
REQ-022 On good: humidity <= min(B0,100), temperature <= B2, error <= 0, valid pulses 1 cycle, -> IDLE.
REQ-023 On bad checksum or any timeout: outputs humidity/temperature unchanged, error <= 1, no valid pulse, dht_oe=0, -> IDLE.
REQ-024 dht_oe SHALL be 1 only in START; every other state releases the line.
REQ-025 B1 and B3 (decimal parts) SHALL be included in checksum but not output.
REQ-026 Poll timer SHALL restart on every entry to IDLE, so reads are POLL_MS apart regardless of outcome.

Reset
REQ-027 Asserting rst at any time, including mid-frame, SHALL immediately force state IDLE, dht_oe=0, humidity=0, temperature=0, valid=0, error=0, all counters and shift register to 0.
REQ-028 After rst deasserts, behaviour SHALL be identical to power-up (REQ-014).

Structure
REQ-029 State encoding and protocol constants (18_000, 100, 40 us; 40 bits; humidity max 100) SHALL live in shared package greenhouse_pkg.
REQ-030 The us tick generator SHALL be a sub-module us_tick (clk, rst, tick); the synchronizer stays inline.
REQ-031 humidity SHALL connect directly to the existing 8-bit display value path in place of the free-running counter.

Verification (bench: CLK_HZ=1_000_000, POLL_MS=1, behavioural DHT11 model)
REQ-032 Good frame B0..B4 = 55,0,24,0,79 -> dht_oe high 18_000 us, then valid 1 cycle, humidity=55, temperature=24, error=0.
REQ-033 Bad checksum 55,0,24,0,80 -> no valid, error=1, humidity/temperature keep prior values (0 after reset).
REQ-034 Sensor absent (line stays high) -> timeout 100 us after START ends, error=1, next START POLL_MS later.
REQ-035 Frame 120,0,30,0,150 (valid checksum) -> humidity=100 (clamped), temperature=30, valid pulse.
REQ-036 rst asserted during bit 20 of a frame -> same cycle dht_oe=0, all outputs 0; following frame decodes correctly.
REQ-037 Bit widths 26 us (->0) and 70 us (->1), and 40/41 us boundary -> 0/1 respectively.
